// File: rtl/core_pkg.sv
// Shared constants and types for the 64-bit RISC-V core pipeline.
package core_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_ADDR_W = 6;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    // funct3 encodings of the load instructions; 3'b111 is illegal
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic [2:0]            addr_low;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       read_data;
    } wb_slot_t;

endpackage

// File: rtl/load_align.sv
// Combinational load-data alignment and extension, plus misaligned/illegal detection.
module load_align
    import core_pkg::*;
(
    input  logic [XLEN-1:0] data_i,
    input  logic [2:0]      funct3_i,
    input  logic [2:0]      offset_i,
    output logic [XLEN-1:0] value_o,
    output logic            fault_o
);

    logic [XLEN-1:0] shifted;

    assign shifted = data_i >> {offset_i, 3'b000};

    always_comb begin
        value_o = '0;
        fault_o = 1'b0;
        case (funct3_i)
            F3_LB: value_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH: begin
                value_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
                fault_o = offset_i[0];
            end
            F3_LW: begin
                value_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
                fault_o = |offset_i[1:0];
            end
            F3_LD: begin
                value_o = shifted;
                fault_o = |offset_i;
            end
            F3_LBU: value_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU: begin
                value_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
                fault_o = offset_i[0];
            end
            F3_LWU: begin
                value_o = {{(XLEN-32){1'b0}}, shifted[31:0]};
                fault_o = |offset_i[1:0];
            end
            default: fault_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load formatting, register-file write port and retire counter.
module mem_wb_stage
    import core_pkg::*;
(
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  MemValid,
    input  logic                  MemRegWrite,
    input  logic                  MemToReg,
    input  logic [REG_ADDR_W-1:0] MemRd,
    input  logic [2:0]            MemFunct3,
    input  logic [2:0]            MemAddrLow,
    input  logic [XLEN-1:0]       MemAluResult,
    input  logic [XLEN-1:0]       MemReadData,
    output logic                  WbRegWrite,
    output logic [REG_ADDR_W-1:0] WbWriteRegister,
    output logic [XLEN-1:0]       WbWriteData,
    output logic                  LoadFault,
    output logic [63:0]           RetireCount
);

    wb_slot_t        slot_q, slot_d;
    logic [63:0]     retire_q, retire_d;
    logic [XLEN-1:0] aligned;
    logic            align_fault;

    always_comb begin
        slot_d = slot_q;
        if (Flush) begin
            slot_d.valid = 1'b0;
        end else if (!Stall) begin
            slot_d.valid      = MemValid;
            slot_d.reg_write  = MemRegWrite;
            slot_d.mem_to_reg = MemToReg;
            slot_d.rd         = MemRd;
            slot_d.funct3     = MemFunct3;
            slot_d.addr_low   = MemAddrLow;
            slot_d.alu_result = MemAluResult;
            slot_d.read_data  = MemReadData;
        end
    end

    // An instruction retires on the edge where it leaves the WB slot.
    assign retire_d = retire_q + {63'd0, slot_q.valid & ~Stall};

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            slot_q   <= '0;
            retire_q <= '0;
        end else begin
            slot_q   <= slot_d;
            retire_q <= retire_d;
        end
    end

    load_align u_load_align (
        .data_i   (slot_q.read_data),
        .funct3_i (slot_q.funct3),
        .offset_i (slot_q.addr_low),
        .value_o  (aligned),
        .fault_o  (align_fault)
    );

    always_comb begin
        LoadFault       = slot_q.valid & slot_q.mem_to_reg & align_fault;
        WbWriteRegister = slot_q.rd;
        if (LoadFault) begin
            WbWriteData = '0;
        end else if (slot_q.mem_to_reg) begin
            WbWriteData = aligned;
        end else begin
            WbWriteData = slot_q.alu_result;
        end
        WbRegWrite = slot_q.valid & slot_q.reg_write & (slot_q.rd != REG_ZERO) & ~LoadFault;
    end

    assign RetireCount = retire_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table, directed sequences, random vs. model.
module tb_mem_wb_stage;

    logic        Clock, ResetN, Stall, Flush, MemValid, MemRegWrite, MemToReg;
    logic [5:0]  MemRd;
    logic [2:0]  MemFunct3, MemAddrLow;
    logic [63:0] MemAluResult, MemReadData;
    logic        WbRegWrite, LoadFault;
    logic [5:0]  WbWriteRegister;
    logic [63:0] WbWriteData, RetireCount;

    int n_cmp = 0;
    int n_bad = 0;

    mem_wb_stage dut (
        .Clock           (Clock),
        .ResetN          (ResetN),
        .Stall           (Stall),
        .Flush           (Flush),
        .MemValid        (MemValid),
        .MemRegWrite     (MemRegWrite),
        .MemToReg        (MemToReg),
        .MemRd           (MemRd),
        .MemFunct3       (MemFunct3),
        .MemAddrLow      (MemAddrLow),
        .MemAluResult    (MemAluResult),
        .MemReadData     (MemReadData),
        .WbRegWrite      (WbRegWrite),
        .WbWriteRegister (WbWriteRegister),
        .WbWriteData     (WbWriteData),
        .LoadFault       (LoadFault),
        .RetireCount     (RetireCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: the instruction sitting in WB and the retired count
    typedef struct {
        bit          valid;
        bit          rw;
        bit          m2r;
        logic [5:0]  rd;
        logic [2:0]  f3;
        logic [2:0]  off;
        logic [63:0] alu;
        logic [63:0] raw;
    } ref_slot_t;

    ref_slot_t   m_slot;
    bit          m_known;
    logic [63:0] m_cnt;

    typedef struct {
        bit          rw;
        bit          m2r;
        logic [5:0]  rd;
        logic [2:0]  f3;
        logic [2:0]  off;
        logic [63:0] alu;
        logic [63:0] raw;
        bit          exp_we;
        bit          exp_fault;
        logic [63:0] exp_data;
    } vec_t;

    function automatic logic [63:0] ld_val(logic [2:0] f3, logic [2:0] off, logic [63:0] raw);
        logic [63:0] sh;
        byte         b;
        shortint     h;
        int          w;
        sh = raw >> (8 * off);
        b  = sh[7:0];
        h  = sh[15:0];
        w  = sh[31:0];
        case (f3)
            3'd0:    return longint'(b);
            3'd1:    return longint'(h);
            3'd2:    return longint'(w);
            3'd3:    return sh;
            3'd4:    return 64'(sh[7:0]);
            3'd5:    return 64'(sh[15:0]);
            3'd6:    return 64'(sh[31:0]);
            default: return 64'd0;
        endcase
    endfunction

    // Natural alignment: access size is 1 << funct3[1:0] bytes
    function automatic bit bad_load(logic [2:0] f3, logic [2:0] off);
        logic [1:0] sz;
        sz = f3[1:0];
        return (f3 == 3'd7) || ((int'(off) % (1 << sz)) != 0);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_slot  = '{default: '0};
        m_known = 1'b1;
        m_cnt   = '0;
    endtask

    task automatic model_step();
        if (!ResetN) begin
            model_reset();
        end else begin
            if (m_slot.valid && !Stall) m_cnt++;
            if (Flush) begin
                m_slot.valid = 1'b0;
                m_known      = 1'b0;
            end else if (!Stall) begin
                m_slot = '{MemValid, MemRegWrite, MemToReg, MemRd, MemFunct3, MemAddrLow,
                           MemAluResult, MemReadData};
                m_known = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_model(string tag);
        bit          f;
        logic [63:0] d;
        f = m_slot.valid && m_slot.m2r && bad_load(m_slot.f3, m_slot.off);
        d = f ? 64'd0 : (m_slot.m2r ? ld_val(m_slot.f3, m_slot.off, m_slot.raw) : m_slot.alu);
        chk({tag, ".fault"}, 64'(LoadFault), 64'(f));
        chk({tag, ".we"}, 64'(WbRegWrite), 64'(m_slot.valid && m_slot.rw && m_slot.rd != 0 && !f));
        chk({tag, ".cnt"}, RetireCount, m_cnt);
        if (m_known) begin
            chk({tag, ".rd"}, 64'(WbWriteRegister), 64'(m_slot.rd));
            chk({tag, ".data"}, WbWriteData, d);
        end
    endtask

    task automatic drive(bit v, bit rw, bit m2r, logic [5:0] rd, logic [2:0] f3,
                         logic [2:0] off, logic [63:0] alu, logic [63:0] raw);
        MemValid     = v;
        MemRegWrite  = rw;
        MemToReg     = m2r;
        MemRd        = rd;
        MemFunct3    = f3;
        MemAddrLow   = off;
        MemAluResult = alu;
        MemReadData  = raw;
    endtask

    localparam logic [63:0] RAW = 64'h8877665544332211;

    vec_t        vecs[13];
    logic [63:0] saved_data, saved_cnt;
    logic [5:0]  saved_rd;

    initial begin
        vecs[0]  = '{1, 1, 6'd7, 3'd0, 3'd7, 64'h0, RAW, 1, 0, 64'hFFFFFFFFFFFFFF88};
        vecs[1]  = '{1, 1, 6'd7, 3'd4, 3'd7, 64'h0, RAW, 1, 0, 64'h0000000000000088};
        vecs[2]  = '{1, 1, 6'd7, 3'd1, 3'd6, 64'h0, RAW, 1, 0, 64'hFFFFFFFFFFFF8877};
        vecs[3]  = '{1, 1, 6'd7, 3'd6, 3'd4, 64'h0, RAW, 1, 0, 64'h0000000088776655};
        vecs[4]  = '{1, 1, 6'd7, 3'd3, 3'd0, 64'h0, RAW, 1, 0, RAW};
        vecs[5]  = '{1, 1, 6'd7, 3'd2, 3'd2, 64'h0, RAW, 0, 1, 64'h0};
        vecs[6]  = '{1, 1, 6'd7, 3'd7, 3'd0, 64'h0, RAW, 0, 1, 64'h0};
        vecs[7]  = '{1, 0, 6'd0, 3'd0, 3'd0, 64'hDEAD, RAW, 0, 0, 64'hDEAD};
        vecs[8]  = '{1, 1, 6'd7, 3'd5, 3'd2, 64'h0, RAW, 1, 0, 64'h0000000000004433};
        vecs[9]  = '{1, 1, 6'd7, 3'd2, 3'd4, 64'h0, RAW, 1, 0, 64'hFFFFFFFF88776655};
        vecs[10] = '{1, 1, 6'd7, 3'd3, 3'd4, 64'h0, RAW, 0, 1, 64'h0};
        vecs[11] = '{1, 1, 6'd7, 3'd1, 3'd3, 64'h0, RAW, 0, 1, 64'h0};
        vecs[12] = '{0, 0, 6'd3, 3'd0, 3'd0, 64'hBEEF, RAW, 0, 0, 64'hBEEF};

        ResetN = 1'b0;
        Stall  = 1'b0;
        Flush  = 1'b0;
        drive(1, 1, 0, 6'd9, 3'd0, 3'd0, 64'h5555, RAW);
        model_reset();

        // Reset held while valid traffic is offered
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst.we", 64'(WbRegWrite), 64'd0);
            chk("rst.data", WbWriteData, 64'd0);
            chk("rst.cnt", RetireCount, 64'd0);
            check_model("rst");
        end
        ResetN = 1'b1;
        drive(1, 1, 0, 6'd5, 3'd0, 3'd0, 64'h1234, RAW);
        tick();
        chk("first.we", 64'(WbRegWrite), 64'd1);
        chk("first.rd", 64'(WbWriteRegister), 64'd5);
        chk("first.data", WbWriteData, 64'h1234);
        drive(0, 0, 0, 6'd0, 3'd0, 3'd0, 64'h0, 64'h0);
        tick();
        chk("first.cnt", RetireCount, 64'd1);
        check_model("first");

        // Vector table: loads, faults, x0 and non-writing ops
        for (int i = 0; i < 13; i++) begin
            drive(1, vecs[i].rw, vecs[i].m2r, vecs[i].rd, vecs[i].f3, vecs[i].off,
                  vecs[i].alu, vecs[i].raw);
            tick();
            chk($sformatf("vec%0d.we", i), 64'(WbRegWrite), 64'(vecs[i].exp_we));
            chk($sformatf("vec%0d.fault", i), 64'(LoadFault), 64'(vecs[i].exp_fault));
            chk($sformatf("vec%0d.data", i), WbWriteData, vecs[i].exp_data);
            chk($sformatf("vec%0d.cnt", i), RetireCount, m_cnt);
        end

        // Stall for three cycles with a valid slot
        drive(1, 1, 0, 6'd12, 3'd0, 3'd0, 64'hCAFEF00D, RAW);
        tick();
        saved_data = m_slot.alu;
        saved_rd   = m_slot.rd;
        saved_cnt  = m_cnt;
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 6'($urandom_range(1, 31)), 3'd0, 3'd0, {$urandom, $urandom}, RAW);
            tick();
            chk("stall.we", 64'(WbRegWrite), 64'd1);
            chk("stall.rd", 64'(WbWriteRegister), 64'(saved_rd));
            chk("stall.data", WbWriteData, saved_data);
            chk("stall.cnt", RetireCount, saved_cnt);
        end
        Stall = 1'b0;
        drive(0, 0, 0, 6'd0, 3'd0, 3'd0, 64'h0, 64'h0);
        tick();
        chk("stall.retire", RetireCount, saved_cnt + 64'd1);
        check_model("stall");

        // Flush and Stall together on a valid slot
        drive(1, 1, 0, 6'd4, 3'd0, 3'd0, 64'h77, RAW);
        tick();
        saved_cnt = m_cnt;
        Flush = 1'b1;
        Stall = 1'b1;
        tick();
        chk("flush.we", 64'(WbRegWrite), 64'd0);
        chk("flush.cnt", RetireCount, saved_cnt);
        Flush = 1'b0;
        Stall = 1'b0;
        drive(0, 0, 0, 6'd0, 3'd0, 3'd0, 64'h0, 64'h0);
        tick();
        chk("flush.cnt2", RetireCount, saved_cnt);
        check_model("flush");

        // Reset asserted in the middle of a stall
        drive(1, 1, 0, 6'd8, 3'd0, 3'd0, 64'h99, RAW);
        tick();
        Stall = 1'b1;
        tick();
        #2 ResetN = 1'b0;
        model_reset();
        #1;
        chk("rststall.we", 64'(WbRegWrite), 64'd0);
        chk("rststall.rd", 64'(WbWriteRegister), 64'd0);
        chk("rststall.data", WbWriteData, 64'd0);
        chk("rststall.cnt", RetireCount, 64'd0);
        @(posedge Clock);
        #1;
        ResetN = 1'b1;
        Stall  = 1'b0;

        // Back-to-back stream of ten ALU ops
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 6'(i + 1), 3'd0, 3'd0, 64'hA000 + 64'(i), RAW);
            tick();
            chk($sformatf("stream%0d.rd", i), 64'(WbWriteRegister), 64'(i + 1));
            chk($sformatf("stream%0d.data", i), WbWriteData, 64'hA000 + 64'(i));
            chk($sformatf("stream%0d.we", i), 64'(WbRegWrite), 64'd1);
        end
        drive(0, 0, 0, 6'd0, 3'd0, 3'd0, 64'h0, 64'h0);
        tick();
        chk("stream.cnt", RetireCount, 64'd10);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            Stall = ($urandom_range(0, 3) == 0);
            Flush = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  6'($urandom_range(0, 31)), 3'($urandom), 3'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom});
            tick();
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back formatting for the 64-bit RISC-V core.
- Captures memory-stage results and aligns/extends load data.
- Drives the register file write port (write register, write data, write enable) and exports a write-back forwarding tap for decode.
- Flags misaligned or illegal loads and keeps a retired-instruction counter.

Parameters:
- XLEN, 64, datapath width.
- REG_ADDR_W, 6, register index width; matches the register file port; upper bit always 0.

Ports:
- Clock  in  1  rising-edge clock.
- ResetN  in  1  asynchronous active-low reset.
- Stall  in  1  hold the WB slot.
- Flush  in  1  kill the incoming MEM slot.
- MemValid  in  1  MEM slot holds a real instruction.
- MemRegWrite  in  1  instruction writes rd.
- MemToReg  in  1  1 = load data, 0 = ALU result.
- MemRd  in  REG_ADDR_W  destination register.
- MemFunct3  in  3  load type.
- MemAddrLow  in  3  byte offset within the doubleword.
- MemAluResult  in  XLEN  ALU result.
- MemReadData  in  XLEN  raw doubleword from data memory.
- WbRegWrite  out  1  register file write enable.
- WbWriteRegister  out  REG_ADDR_W  register file write index.
- WbWriteData  out  XLEN  register file write data.
- LoadFault  out  1  misaligned or illegal load in the WB slot.
- RetireCount  out  64  retired-instruction count.

Behaviour:
- Async reset (ResetN=0): slot valid=0; all captured fields=0; RetireCount=0.
  - Outputs during and after reset until the first capture: WbRegWrite=0, WbWriteRegister=0, WbWriteData=0, LoadFault=0.
- Capture at posedge Clock, priority order:
  - Flush=1: valid<=0, other fields don't-care; Flush overrides Stall.
  - else Stall=1: hold all fields.
  - else: capture every Mem* input into the slot.
- Latency: one cycle from Mem* inputs to Wb* outputs. Wb* outputs are combinational from slot registers only, with no path from Mem* inputs.
- Load alignment, applied when MemToReg=1:
  - shifted = MemReadData >> (8*MemAddrLow).
  - funct3 000/001/010/011: sign-extend 8/16/32/64 bits.
  - funct3 100/101/110: zero-extend 8/16/32 bits.
  - funct3 111: illegal.
- Fault conditions set LoadFault=1 when valid & MemToReg and any of:
  - funct3=111.
  - halfword with offset[0]≠0.
  - word with offset[1:0]≠0.
  - doubleword with offset≠0.
- WbWriteData:
  - MemToReg=0: captured ALU result.
  - MemToReg=1 and no fault: aligned load value.
  - fault: 0.
- WbRegWrite = valid & RegWrite & (Rd≠0) & ~LoadFault. x0 is never written.
- WbWriteRegister = captured Rd, driven even when WbRegWrite=0. Decode uses WbRegWrite/WbWriteRegister/WbWriteData as its forwarding tap, because the register file reads combinationally and writes at the edge.
- RetireCount increments by 1 at posedge when valid=1 and Stall=0. It does so regardless of fault, rd, or Flush. Wraps 2^64-1 → 0.
- Stall held for N cycles: the same write is presented for N+1 edges (idempotent); RetireCount increments exactly once.
- Reset asserted mid-stall: slot cleared immediately, count cleared.

Decomposition:
- Shared package (core_pkg):
  - funct3 load encodings: LB, LH, LW, LD, LBU, LHU, LWU.
  - XLEN.
  - REG_ADDR_W.
  - Zero-register index constant.
- One sub-module: load_align. Purely combinational; inputs are raw data, funct3 and offset; outputs are aligned value and misalign/illegal flag. Reused later by the store path's inverse.

Test Plan:
- Reset: hold ResetN=0 while driving valid traffic → all outputs 0, RetireCount=0; release, capture ALU op rd=5, result=0x1234 → next cycle WbRegWrite=1, WbWriteRegister=5, WbWriteData=0x1234, RetireCount=1 after the following edge.
- Loads from MemReadData=0x8877665544332211:
  - lb, offset 7 → 0xFFFFFFFFFFFFFF88.
  - lbu, offset 7 → 0x88.
  - lh, offset 6 → 0xFFFFFFFFFFFF8877.
  - lwu, offset 4 → 0x88776655.
  - ld, offset 0 → full value.
- Faults: lw with offset 2 → LoadFault=1, WbRegWrite=0, WbWriteData=0; funct3=111 → LoadFault=1; RetireCount still increments.
- x0 write: ALU op rd=0, RegWrite=1 → WbRegWrite=0.
- Stall and flush:
  - Stall 3 cycles with a valid slot → outputs constant for 4 edges, RetireCount +1 total.
  - Flush and Stall asserted together → next slot valid=0, WbRegWrite=0, no increment.
- Back-to-back stream of 10 valid ALU ops with no stalls → each appears exactly one cycle after input, in order; RetireCount=10.
